// File: rtl/adder_harness_pkg.sv
// Shared definitions for the adder launch/capture harness.
//   state_e          : harness FSM states
//   DEF_*            : default parameter values
//   cnt_width()      : settle counter width for a given settle window
package adder_harness_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OUT    = 2'd2
    } state_e;

    localparam int unsigned DEF_WIDTH         = 9;
    localparam int unsigned DEF_SETTLE_CYCLES = 2;
    localparam int unsigned DEF_ERR_W         = 16;

    function automatic int unsigned cnt_width(input int unsigned settle);
        return $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/adder_launch_capture_if.sv
// Handshake and adder-facing bus of the launch/capture harness.
//   upstream   : i_op_a, i_op_b, i_valid, o_ready
//   adder      : o_add_term1, o_add_term2 (to adder), i_sum, i_cout (from adder)
//   downstream : o_sum, o_cout, o_mismatch, o_valid, i_ready
// slave is the harness view; master is the environment (source/sink/adder) view.
interface adder_launch_capture_if
    import adder_harness_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] i_op_a;
    logic [WIDTH-1:0] i_op_b;
    logic             i_valid;
    logic             o_ready;

    logic [WIDTH-1:0] o_add_term1;
    logic [WIDTH-1:0] o_add_term2;
    logic [WIDTH-1:0] i_sum;
    logic             i_cout;

    logic [WIDTH-1:0] o_sum;
    logic             o_cout;
    logic             o_mismatch;
    logic             o_valid;
    logic             i_ready;

    modport slave (
        input  i_op_a, i_op_b, i_valid, i_sum, i_cout, i_ready,
        output o_ready, o_add_term1, o_add_term2, o_sum, o_cout, o_mismatch, o_valid
    );

    modport master (
        output i_op_a, i_op_b, i_valid, i_sum, i_cout, i_ready,
        input  o_ready, o_add_term1, o_add_term2, o_sum, o_cout, o_mismatch, o_valid
    );

endinterface

// File: rtl/adder_result_checker.sv
// Combinational adder result checker.
//   i_a, i_b   : operands presented to the adder
//   i_sum      : adder sum
//   i_cout     : adder carry-out
//   o_mismatch : {i_cout,i_sum} differs from the (WIDTH+1)-bit sum i_a+i_b
module adder_result_checker
    import adder_harness_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_sum,
    input  logic             i_cout,
    output logic             o_mismatch
);

    logic [WIDTH:0] ref_sum;

    always_comb begin
        ref_sum    = {1'b0, i_a} + {1'b0, i_b};
        o_mismatch = ({i_cout, i_sum} != ref_sum);
    end

endmodule

// File: rtl/adder_launch_capture.sv
// Launch/capture harness around a gate-level adder macro.
// Registers an operand pair onto the adder terms, waits SETTLE_CYCLES edges,
// captures sum/cout with a mismatch flag and presents them downstream.
//   i_clk, i_rst : clock, async active-high reset
//   bus          : upstream handshake, adder terms/results, downstream handshake
//   i_clr_err    : synchronous clear of the mismatch counter (wins over increment)
//   o_err_count  : saturating mismatch count
module adder_launch_capture
    import adder_harness_pkg::*;
#(
    parameter int unsigned WIDTH         = DEF_WIDTH,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned ERR_W         = DEF_ERR_W
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    adder_launch_capture_if.slave  bus,
    input  logic                   i_clr_err,
    output logic [ERR_W-1:0]       o_err_count
);

    localparam int unsigned CNT_W = cnt_width(SETTLE_CYCLES);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  term1_q, term1_d;
    logic [WIDTH-1:0]  term2_q, term2_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              mis_q, mis_d;
    logic [ERR_W-1:0]  err_q, err_d;

    logic              ready;
    logic              accept;
    logic              capture;
    logic              mis_w;

    adder_result_checker #(
        .WIDTH (WIDTH)
    ) u_checker (
        .i_a        (term1_q),
        .i_b        (term2_q),
        .i_sum      (bus.i_sum),
        .i_cout     (bus.i_cout),
        .o_mismatch (mis_w)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            term1_q <= '0;
            term2_q <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            mis_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            term1_q <= term1_d;
            term2_q <= term2_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        term1_d = term1_q;
        term2_d = term2_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        mis_d   = mis_q;
        err_d   = err_q;
        ready   = 1'b0;

        unique case (state_q)
            IDLE:    ready = 1'b1;
            SETTLE:  ready = 1'b0;
            OUT:     ready = bus.i_ready;
            default: ready = 1'b0;
        endcase

        accept  = bus.i_valid && ready;
        // Counter reaching 1 marks the edge SETTLE_CYCLES after launch.
        capture = (state_q == SETTLE) && (cnt_q == CNT_W'(1));

        unique case (state_q)
            IDLE: begin
                if (accept) state_d = SETTLE;
            end
            SETTLE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (capture) state_d = OUT;
            end
            OUT: begin
                // Back-to-back: a new pair can be accepted on the same edge
                // the current result is consumed.
                if (bus.i_ready) state_d = accept ? SETTLE : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            term1_d = bus.i_op_a;
            term2_d = bus.i_op_b;
            cnt_d   = CNT_W'(SETTLE_CYCLES);
        end

        if (capture) begin
            sum_d  = bus.i_sum;
            cout_d = bus.i_cout;
            mis_d  = mis_w;
        end

        if (i_clr_err) begin
            err_d = '0;
        end else if (capture && mis_w && (err_q != '1)) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    assign bus.o_ready     = ready;
    assign bus.o_valid     = (state_q == OUT);
    assign bus.o_add_term1 = term1_q;
    assign bus.o_add_term2 = term2_q;
    assign bus.o_sum       = sum_q;
    assign bus.o_cout      = cout_q;
    assign bus.o_mismatch  = mis_q;
    assign o_err_count     = err_q;

endmodule

// File: tb/tb_adder_launch_capture.sv
// Self-checking bench for adder_launch_capture.
// DUT A: ERR_W=16, adder model switchable between ideal and sum-bit-4 stuck-at-0.
// DUT B: ERR_W=2, adder model permanently faulty; shares stimulus with DUT A.
module tb_adder_launch_capture;
    import adder_harness_pkg::*;

    localparam int unsigned W  = 9;
    localparam int unsigned SC = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         clr_a = 1'b0;
    logic         flt_a = 1'b0;

    logic [15:0]  err_cnt_a;
    logic [1:0]   err_cnt_b;

    adder_launch_capture_if #(.WIDTH(W)) bus_a ();
    adder_launch_capture_if #(.WIDTH(W)) bus_b ();

    assign bus_a.i_op_a  = op_a;
    assign bus_a.i_op_b  = op_b;
    assign bus_a.i_valid = in_valid;
    assign bus_a.i_ready = out_ready;
    assign bus_b.i_op_a  = op_a;
    assign bus_b.i_op_b  = op_b;
    assign bus_b.i_valid = in_valid;
    assign bus_b.i_ready = out_ready;

    // Adder macro stand-ins: ideal, or with sum bit 4 stuck at 0.
    logic [W:0] raw_a, raw_b;
    assign raw_a         = {1'b0, bus_a.o_add_term1} + {1'b0, bus_a.o_add_term2};
    assign raw_b         = {1'b0, bus_b.o_add_term1} + {1'b0, bus_b.o_add_term2};
    assign bus_a.i_sum   = flt_a ? (raw_a[W-1:0] & 9'h1EF) : raw_a[W-1:0];
    assign bus_a.i_cout  = raw_a[W];
    assign bus_b.i_sum   = raw_b[W-1:0] & 9'h1EF;
    assign bus_b.i_cout  = raw_b[W];

    adder_launch_capture #(.WIDTH(W), .SETTLE_CYCLES(SC), .ERR_W(16)) u_dut_a (
        .i_clk       (clk),
        .i_rst       (rst),
        .bus         (bus_a.slave),
        .i_clr_err   (clr_a),
        .o_err_count (err_cnt_a)
    );

    adder_launch_capture #(.WIDTH(W), .SETTLE_CYCLES(SC), .ERR_W(2)) u_dut_b (
        .i_clk       (clk),
        .i_rst       (rst),
        .bus         (bus_b.slave),
        .i_clr_err   (1'b0),
        .o_err_count (err_cnt_b)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: the single outstanding pair and the two counters.
    int unsigned cur_a, cur_b;
    bit          cur_f;
    int unsigned model_err_a = 0;
    int unsigned model_err_b = 0;

    // Enter at a negedge; leaves at the negedge after the accept edge.
    task automatic present(input int unsigned a, input int unsigned b, input bit f);
        int unsigned w;
        op_a = W'(a); op_b = W'(b); in_valid = 1'b1; flt_a = f;
        w = 0;
        #1;
        while (!bus_a.o_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_eq("accept_ready", 32'(bus_a.o_ready), 32'd1);
        cur_a = a; cur_b = b; cur_f = f;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("launch_term1", 32'(bus_a.o_add_term1), 32'(a));
        check_eq("launch_term2", 32'(bus_a.o_add_term2), 32'(b));
    endtask

    // Enter at the negedge after an accept edge; waits for the result, checks it,
    // applies backpressure for 'hold' cycles, then consumes it, optionally
    // accepting the next pair on the same edge.
    task automatic collect(input bit clr_cap, input int unsigned hold, input bit chain,
                           input int unsigned na, input int unsigned nb, input bit nf);
        int unsigned lat;
        int unsigned full, obs;
        bit          mis_a, mis_b;
        full  = cur_a + cur_b;
        obs   = cur_f ? (full & ~32'd16) : full;
        mis_a = (obs != full);
        mis_b = ((full & 32'd16) != 0);
        lat = 0;
        while (!bus_a.o_valid && lat < 16) begin
            clr_a = (clr_cap && lat == SC - 1);
            @(posedge clk);
            lat++;
            @(negedge clk);
            clr_a = 1'b0;
        end
        check_eq("latency", lat, SC);
        if (clr_cap) model_err_a = 0;
        else if (mis_a && model_err_a < 65535) model_err_a++;
        if (mis_b && model_err_b < 3) model_err_b++;

        check_eq("sum", 32'(bus_a.o_sum), obs % 512);
        check_eq("cout", 32'(bus_a.o_cout), obs / 512);
        check_eq("mismatch", 32'(bus_a.o_mismatch), 32'(mis_a));
        check_eq("err_count", 32'(err_cnt_a), model_err_a);
        check_eq("b_valid", 32'(bus_b.o_valid), 32'd1);
        check_eq("b_mismatch", 32'(bus_b.o_mismatch), 32'(mis_b));
        check_eq("b_err_sat", 32'(err_cnt_b), model_err_b);
        check_eq("out_ready_low", 32'(bus_a.o_ready), 32'd0);

        for (int unsigned h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("hold_valid", 32'(bus_a.o_valid), 32'd1);
            check_eq("hold_sum", 32'(bus_a.o_sum), obs % 512);
            check_eq("hold_mis", 32'(bus_a.o_mismatch), 32'(mis_a));
            check_eq("hold_ready", 32'(bus_a.o_ready), 32'd0);
            check_eq("hold_term1", 32'(bus_a.o_add_term1), cur_a);
        end

        out_ready = 1'b1;
        if (chain) begin
            op_a = W'(na); op_b = W'(nb); in_valid = 1'b1; flt_a = nf;
        end
        #1;
        check_eq("release_ready", 32'(bus_a.o_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        if (chain) begin
            cur_a = na; cur_b = nb; cur_f = nf;
            check_eq("chain_valid", 32'(bus_a.o_valid), 32'd0);
            check_eq("chain_term1", 32'(bus_a.o_add_term1), na);
            check_eq("chain_term2", 32'(bus_a.o_add_term2), nb);
        end else begin
            check_eq("idle_valid", 32'(bus_a.o_valid), 32'd0);
            check_eq("idle_ready", 32'(bus_a.o_ready), 32'd1);
        end
    endtask

    initial begin
        int unsigned na, nb;
        bit nf, ch;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", 32'(bus_a.o_valid), 32'd0);
        check_eq("rst_ready", 32'(bus_a.o_ready), 32'd1);
        check_eq("rst_term1", 32'(bus_a.o_add_term1), 32'd0);
        check_eq("rst_sum", 32'(bus_a.o_sum), 32'd0);
        check_eq("rst_err", 32'(err_cnt_a), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed: ideal adder corner values.
        present(255, 1, 0);   collect(0, 0, 0, 0, 0, 0);
        present(511, 511, 0); collect(0, 0, 0, 0, 0, 0);
        present(0, 0, 0);     collect(0, 0, 0, 0, 0, 0);

        // Faulty adder, clear coinciding with the third mismatching capture.
        present(16, 0, 1); collect(0, 0, 0, 0, 0, 0);
        present(16, 0, 1); collect(0, 0, 0, 0, 0, 0);
        present(16, 0, 1); collect(1, 0, 0, 0, 0, 0);

        // Backpressure for 5 cycles, then release straight into a new pair.
        present(300, 200, 0); collect(0, 5, 1, 100, 28, 0);
        collect(0, 0, 0, 0, 0, 0);

        // Randomized traffic.
        present($urandom_range(0, 511), $urandom_range(0, 511), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 40; i++) begin
            na = $urandom_range(0, 511);
            nb = $urandom_range(0, 511);
            nf = 1'($urandom_range(0, 1));
            ch = (i < 39) && ($urandom_range(0, 1) == 1);
            collect(($urandom_range(0, 7) == 0), $urandom_range(0, 2), ch, na, nb, nf);
            if (!ch && i < 39) present(na, nb, nf);
        end

        // Async reset while settling.
        present(123, 321, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_term1", 32'(bus_a.o_add_term1), 32'd0);
        check_eq("arst_term2", 32'(bus_a.o_add_term2), 32'd0);
        check_eq("arst_valid", 32'(bus_a.o_valid), 32'd0);
        check_eq("arst_err_b", 32'(err_cnt_b), 32'd0);
        model_err_a = 0;
        model_err_b = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("post_rst_valid", 32'(bus_a.o_valid), 32'd0);
            check_eq("post_rst_ready", 32'(bus_a.o_ready), 32'd1);
        end

        // Five mismatches on the permanently faulty adder saturate the 2-bit count.
        for (int i = 0; i < 5; i++) begin
            present(16 + 32 * i, 0, 1);
            collect(0, 0, 0, 0, 0, 0);
        end
        check_eq("b_err_final", 32'(err_cnt_b), 32'd3);
        check_eq("a_err_final", 32'(err_cnt_a), 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
